// File: rtl/ethernet_pkg.sv
// Shared Ethernet TX types: pacer FSM states, the AXI-stream beat bundle and tkeep byte counting.
package ethernet_pkg;

   typedef enum logic [1:0] {P_IDLE, P_FRAME, P_DROP, P_GAP} pacer_state_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } axis_beat_t;

   function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, keep[i]};
      return n;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream beat buffer; a pushed beat is presented on the following cycle.
// s_rdy is a flop (entries < 2), so there is no combinational path from m_rdy to s_rdy.
module axis_skid_buf
   import ethernet_pkg::*;
(
   input  logic       clk156,
   input  logic       sys_rst_n,
   input  logic       s_vld,
   output logic       s_rdy,
   input  axis_beat_t s_dat,
   output logic       m_vld,
   input  logic       m_rdy,
   output axis_beat_t m_dat
);

   axis_beat_t head, tail;
   logic [1:0] cnt, cnt_nxt;
   logic       push, pop;

   assign push    = s_vld && s_rdy;
   assign pop     = m_vld && m_rdy;
   assign m_vld   = (cnt != 2'd0);
   assign m_dat   = head;
   assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk156 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= 2'd0;
         s_rdy <= 1'b0;
      end else begin
         // head always holds the oldest beat; tail only fills when head is busy
         if (pop && cnt == 2'd2)
            head <= tail;
         else if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
            head <= s_dat;
         if (push && cnt == 2'd1 && !pop)
            tail <= s_dat;
         cnt   <= cnt_nxt;
         s_rdy <= (cnt_nxt < 2'd2);
      end
   end

endmodule

// File: rtl/eth_tx_pacer.sv
// TX frame pacer: forwards beats with 1-cycle latency, truncates frames at max_beats, forces ifg_len idle cycles.
// Backpressure: s_axis_tx_tready is flop-derived (buffer space, FSM state), never combinational from m_axis_tx_tready.
// Statistics counters exist only when ETH_TX_PACER_STATS_EN is defined; otherwise they are tied to zero.
module eth_tx_pacer
   import ethernet_pkg::*;
#(
   parameter logic [27:0] ifg_len   = 28'd16,
   parameter logic [15:0] max_beats = 16'd128
) (
   input  logic        clk156,
   input  logic        sys_rst_n,
   input  logic        s_axis_tx_tvalid,
   output logic        s_axis_tx_tready,
   input  logic [63:0] s_axis_tx_tdata,
   input  logic [7:0]  s_axis_tx_tkeep,
   input  logic        s_axis_tx_tlast,
   input  logic        s_axis_tx_tuser,
   output logic        m_axis_tx_tvalid,
   input  logic        m_axis_tx_tready,
   output logic [63:0] m_axis_tx_tdata,
   output logic [7:0]  m_axis_tx_tkeep,
   output logic        m_axis_tx_tlast,
   output logic        m_axis_tx_tuser,
   output logic [31:0] frame_cnt,
   output logic [47:0] byte_cnt,
   output logic [15:0] trunc_cnt
);

   pacer_state_t state, state_nxt;
   logic [15:0]  beat_cnt, beat_cnt_nxt;
   logic [27:0]  gap_cnt, gap_cnt_nxt;
   logic [1:0]   rst_sync;
   logic         buf_rdy, push, accept, at_limit;
   axis_beat_t   push_dat, out_dat;

   // Dropped beats bypass the buffer, so P_DROP keeps tready high regardless of buffer space
   assign s_axis_tx_tready = rst_sync[1] && ((state == P_DROP) || (state != P_GAP && buf_rdy));
   assign accept           = s_axis_tx_tvalid && s_axis_tx_tready;
   assign at_limit         = ((beat_cnt + 16'd1) == max_beats);

   always_ff @(posedge clk156 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rst_sync <= 2'b00;
         state    <= P_IDLE;
         beat_cnt <= 16'd0;
         gap_cnt  <= 28'd0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
         gap_cnt  <= gap_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      beat_cnt_nxt  = beat_cnt;
      gap_cnt_nxt   = gap_cnt;
      push          = 1'b0;
      push_dat.data = s_axis_tx_tdata;
      push_dat.keep = s_axis_tx_tkeep;
      push_dat.last = s_axis_tx_tlast;
      push_dat.user = s_axis_tx_tuser;
      unique case (state)
         P_IDLE, P_FRAME: begin
            if (accept) begin
               push = 1'b1;
               if (s_axis_tx_tlast) begin
                  beat_cnt_nxt = 16'd0;
                  gap_cnt_nxt  = 28'd0;
                  state_nxt    = (ifg_len == 28'd0) ? P_IDLE : P_GAP;
               end else if (at_limit) begin
                  push_dat.last = 1'b1;
                  push_dat.user = 1'b1;
                  beat_cnt_nxt  = 16'd0;
                  state_nxt     = P_DROP;
               end else begin
                  beat_cnt_nxt = beat_cnt + 16'd1;
                  state_nxt    = P_FRAME;
               end
            end
         end
         P_DROP: begin
            if (accept && s_axis_tx_tlast) begin
               gap_cnt_nxt = 28'd0;
               state_nxt   = (ifg_len == 28'd0) ? P_IDLE : P_GAP;
            end
         end
         P_GAP: begin
            if (gap_cnt >= ifg_len - 28'd1) state_nxt = P_IDLE;
            gap_cnt_nxt = (gap_cnt == '1) ? gap_cnt : gap_cnt + 28'd1;
         end
         default: state_nxt = P_IDLE;
      endcase
   end

   axis_skid_buf u_buf (
      .clk156    (clk156),
      .sys_rst_n (sys_rst_n),
      .s_vld     (push),
      .s_rdy     (buf_rdy),
      .s_dat     (push_dat),
      .m_vld     (m_axis_tx_tvalid),
      .m_rdy     (m_axis_tx_tready),
      .m_dat     (out_dat)
   );

   assign m_axis_tx_tdata = out_dat.data;
   assign m_axis_tx_tkeep = out_dat.keep;
   assign m_axis_tx_tlast = out_dat.last;
   assign m_axis_tx_tuser = out_dat.user;

`ifdef ETH_TX_PACER_STATS_EN
   logic [31:0] frame_q;
   logic [47:0] byte_q;
   logic [15:0] trunc_q;
   logic        out_hs, trunc_evt;

   assign out_hs    = m_axis_tx_tvalid && m_axis_tx_tready;
   assign trunc_evt = accept && (state == P_IDLE || state == P_FRAME) && !s_axis_tx_tlast && at_limit;

   always_ff @(posedge clk156 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_q <= 32'd0;
         byte_q  <= 48'd0;
         trunc_q <= 16'd0;
      end else begin
         if (out_hs && out_dat.last) frame_q <= frame_q + 32'd1;
         if (out_hs)                 byte_q  <= byte_q + {44'd0, keep_bytes(out_dat.keep)};
         if (trunc_evt)              trunc_q <= trunc_q + 16'd1;
      end
   end

   assign frame_cnt = frame_q;
   assign byte_cnt  = byte_q;
   assign trunc_cnt = trunc_q;
`else
   assign frame_cnt = 32'd0;
   assign byte_cnt  = 48'd0;
   assign trunc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_eth_tx_pacer.sv
// Bench for eth_tx_pacer: instance a (ifg 4, max 16) and instance b (ifg 0, max 4) checked against a beat scoreboard.
module tb_eth_tx_pacer;

   localparam int A_MAX = 16;
   localparam int B_MAX = 4;
`ifdef ETH_TX_PACER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
      int          e;
   } beat_t;

   logic        clk156 = 1'b0;
   logic        sys_rst_n;
   logic        s_vld [2];
   logic        s_rdy [2];
   logic [63:0] s_dat [2];
   logic [7:0]  s_keep [2];
   logic        s_last [2];
   logic        s_user [2];
   logic        m_vld [2];
   logic        m_rdy [2];
   logic [63:0] m_dat [2];
   logic [7:0]  m_keep [2];
   logic        m_last [2];
   logic        m_user [2];
   logic [31:0] frame_cnt [2];
   logic [47:0] byte_cnt [2];
   logic [15:0] trunc_cnt [2];

   beat_t       exp_q0[$];
   beat_t       exp_q1[$];
   int          acc_log[$];
   int          out_log[$];
   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   int          in_cnt [2];
   int          out_cnt [2];
   logic [31:0] fc_m [2];
   logic [47:0] bc_m [2];
   logic [15:0] tc_m [2];
   bit          tog [2];
   bit          lat_chk [2];
   bit          acc [2];
   bit          occ_chk;
   bit          saw_full;

   always #5 clk156 = ~clk156;

   eth_tx_pacer #(.ifg_len(28'd4), .max_beats(16'd16)) dut_a (
      .clk156(clk156), .sys_rst_n(sys_rst_n),
      .s_axis_tx_tvalid(s_vld[0]), .s_axis_tx_tready(s_rdy[0]), .s_axis_tx_tdata(s_dat[0]),
      .s_axis_tx_tkeep(s_keep[0]), .s_axis_tx_tlast(s_last[0]), .s_axis_tx_tuser(s_user[0]),
      .m_axis_tx_tvalid(m_vld[0]), .m_axis_tx_tready(m_rdy[0]), .m_axis_tx_tdata(m_dat[0]),
      .m_axis_tx_tkeep(m_keep[0]), .m_axis_tx_tlast(m_last[0]), .m_axis_tx_tuser(m_user[0]),
      .frame_cnt(frame_cnt[0]), .byte_cnt(byte_cnt[0]), .trunc_cnt(trunc_cnt[0])
   );

   eth_tx_pacer #(.ifg_len(28'd0), .max_beats(16'd4)) dut_b (
      .clk156(clk156), .sys_rst_n(sys_rst_n),
      .s_axis_tx_tvalid(s_vld[1]), .s_axis_tx_tready(s_rdy[1]), .s_axis_tx_tdata(s_dat[1]),
      .s_axis_tx_tkeep(s_keep[1]), .s_axis_tx_tlast(s_last[1]), .s_axis_tx_tuser(s_user[1]),
      .m_axis_tx_tvalid(m_vld[1]), .m_axis_tx_tready(m_rdy[1]), .m_axis_tx_tdata(m_dat[1]),
      .m_axis_tx_tkeep(m_keep[1]), .m_axis_tx_tlast(m_last[1]), .m_axis_tx_tuser(m_user[1]),
      .frame_cnt(frame_cnt[1]), .byte_cnt(byte_cnt[1]), .trunc_cnt(trunc_cnt[1])
   );

   task automatic clear_model();
      exp_q0.delete();
      exp_q1.delete();
      for (int i = 0; i < 2; i++) begin
         in_cnt[i] = 0; out_cnt[i] = 0;
         fc_m[i] = 32'd0; bc_m[i] = 48'd0; tc_m[i] = 16'd0;
      end
   endtask

   task automatic observe(input int idx);
      beat_t b;
      bit    have;
      if (m_vld[idx] && m_rdy[idx]) begin
         out_cnt[idx]++;
         have = 1'b0;
         if (idx == 0 && exp_q0.size() > 0) begin b = exp_q0.pop_front(); have = 1'b1; end
         if (idx == 1 && exp_q1.size() > 0) begin b = exp_q1.pop_front(); have = 1'b1; end
         checks++;
         if (!have) begin
            fails++;
            $display("FAIL extra_beat dut%0d: got d=%h last=%b, required no beat", idx, m_dat[idx], m_last[idx]);
         end else begin
            if ({m_dat[idx], m_keep[idx], m_last[idx], m_user[idx]} !== {b.d, b.k, b.l, b.u}) begin
               fails++;
               $display("FAIL beat dut%0d: got d=%h k=%h l=%b u=%b, required d=%h k=%h l=%b u=%b",
                        idx, m_dat[idx], m_keep[idx], m_last[idx], m_user[idx], b.d, b.k, b.l, b.u);
            end
            bc_m[idx] += 48'($countones(b.k));
            if (b.l) fc_m[idx]++;
            if (lat_chk[idx]) begin
               checks++;
               if (cyc + 1 - b.e != 1) begin
                  fails++;
                  $display("FAIL latency dut%0d: got %0d cycles, required 1", idx, cyc + 1 - b.e);
               end
            end
            if (idx == 1) out_log.push_back(cyc + 1);
         end
      end
   endtask

   // Outputs and acceptances are sampled at the falling edge; inputs change 1ns after the rising edge.
   task automatic step();
      @(negedge clk156);
      observe(0);
      observe(1);
      acc[0] = s_vld[0] && s_rdy[0];
      acc[1] = s_vld[1] && s_rdy[1];
      @(posedge clk156);
      cyc++;
      #1;
      for (int i = 0; i < 2; i++) if (tog[i]) m_rdy[i] = !m_rdy[i];
   endtask

   task automatic send_beat(input int idx, input int i, input int n, input logic [7:0] lk, input int maxb);
      beat_t b;
      int    w;
      b.d = {$urandom, $urandom};
      b.k = (i == n) ? lk : 8'hFF;
      b.l = (i == n);
      b.u = 1'($urandom_range(0, 1));
      b.e = 0;
      s_vld[idx] = 1'b1; s_dat[idx] = b.d; s_keep[idx] = b.k; s_last[idx] = b.l; s_user[idx] = b.u;
      w = 0;
      step();
      while (!acc[idx] && w < 50) begin step(); w++; end
      checks++;
      if (!acc[idx]) begin
         fails++;
         $display("FAIL accept_timeout dut%0d beat %0d: got no tready, required acceptance within 50 cycles", idx, i);
      end else begin
         b.e = cyc;
         if (idx == 1) acc_log.push_back(cyc);
         if (i <= maxb) begin
            if (i == maxb && i != n) begin
               b.l = 1'b1; b.u = 1'b1;
               tc_m[idx]++;
            end
            if (idx == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
            in_cnt[idx]++;
         end
         if (occ_chk && idx == 0 && in_cnt[0] - out_cnt[0] == 2) begin
            saw_full = 1'b1;
            checks++;
            if (s_rdy[0] !== 1'b0) begin
               fails++;
               $display("FAIL full_tready: got %b with 2 beats held, required 0", s_rdy[0]);
            end
         end
      end
   endtask

   task automatic send_frame(input int idx, input int n, input logic [7:0] lk, input int maxb);
      for (int i = 1; i <= n; i++) send_beat(idx, i, n, lk, maxb);
      s_vld[idx] = 1'b0;
      s_last[idx] = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 200) begin step(); w++; end
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d/%0d beats outstanding, required 0/0", exp_q0.size(), exp_q1.size());
      end
   endtask

   task automatic check_stats(input int idx);
      checks++;
      if (frame_cnt[idx] !== (STATS ? fc_m[idx] : 32'd0)) begin
         fails++;
         $display("FAIL frame_cnt dut%0d: got %0d, required %0d", idx, frame_cnt[idx], STATS ? fc_m[idx] : 32'd0);
      end
      checks++;
      if (byte_cnt[idx] !== (STATS ? bc_m[idx] : 48'd0)) begin
         fails++;
         $display("FAIL byte_cnt dut%0d: got %0d, required %0d", idx, byte_cnt[idx], STATS ? bc_m[idx] : 48'd0);
      end
      checks++;
      if (trunc_cnt[idx] !== (STATS ? tc_m[idx] : 16'd0)) begin
         fails++;
         $display("FAIL trunc_cnt dut%0d: got %0d, required %0d", idx, trunc_cnt[idx], STATS ? tc_m[idx] : 16'd0);
      end
   endtask

   task automatic release_reset();
      int w;
      step();
      sys_rst_n = 1'b1;
      step();
      checks++;
      if (s_rdy[0] !== 1'b0 || s_rdy[1] !== 1'b0) begin
         fails++;
         $display("FAIL early_tready: got %b%b after first edge, required 00", s_rdy[0], s_rdy[1]);
      end
      w = 0;
      while (!(s_rdy[0] && s_rdy[1]) && w < 8) begin step(); w++; end
      checks++;
      if (!(s_rdy[0] && s_rdy[1])) begin
         fails++;
         $display("FAIL tready_rise: got %b%b after 8 cycles, required 11", s_rdy[0], s_rdy[1]);
      end
   endtask

   task automatic test_reset();
      #2;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (m_vld[i] !== 1'b0 || s_rdy[i] !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake dut%0d: got vld=%b rdy=%b, required 0 0", i, m_vld[i], s_rdy[i]);
         end
         checks++;
         if ({m_dat[i], m_keep[i], m_last[i], m_user[i]} !== 74'd0) begin
            fails++;
            $display("FAIL reset_data dut%0d: got d=%h k=%h, required 0", i, m_dat[i], m_keep[i]);
         end
         checks++;
         if ({frame_cnt[i], byte_cnt[i], trunc_cnt[i]} !== 96'd0) begin
            fails++;
            $display("FAIL reset_stats dut%0d: got %0d/%0d/%0d, required 0", i, frame_cnt[i], byte_cnt[i], trunc_cnt[i]);
         end
      end
      release_reset();
   endtask

   task automatic test_frame_60b();
      int low;
      lat_chk[0] = 1'b1;
      send_frame(0, 8, 8'h0F, A_MAX);
      low = 0;
      while (s_rdy[0] == 1'b0 && low < 20) begin low++; step(); end
      checks++;
      if (low != 4) begin
         fails++;
         $display("FAIL ifg_gap: got %0d tready-low cycles, required 4", low);
      end
      drain();
      lat_chk[0] = 1'b0;
      check_stats(0);
   endtask

   task automatic test_backpressure();
      saw_full = 1'b0;
      occ_chk  = 1'b1;
      tog[0]   = 1'b1;
      send_frame(0, 8, 8'h0F, A_MAX);
      drain();
      tog[0]   = 1'b0;
      m_rdy[0] = 1'b1;
      occ_chk  = 1'b0;
      checks++;
      if (!saw_full) begin
         fails++;
         $display("FAIL buffer_fill: got max occupancy below 2, required 2");
      end
      check_stats(0);
   endtask

   task automatic test_truncate();
      send_frame(1, 6, 8'hFF, B_MAX);
      send_frame(1, 3, 8'h07, B_MAX);
      drain();
      check_stats(1);
   endtask

   task automatic test_back_to_back();
      acc_log.delete();
      out_log.delete();
      send_frame(1, 1, 8'h01, B_MAX);
      send_frame(1, 1, 8'h03, B_MAX);
      send_frame(1, 1, 8'hFF, B_MAX);
      drain();
      checks++;
      if (acc_log.size() != 3 || out_log.size() != 3) begin
         fails++;
         $display("FAIL b2b_count: got %0d in / %0d out, required 3 / 3", acc_log.size(), out_log.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (acc_log[k] != acc_log[k-1] + 1 || out_log[k] != out_log[k-1] + 1) begin
               fails++;
               $display("FAIL b2b_spacing beat %0d: got in gap %0d out gap %0d, required 1 1",
                        k, acc_log[k] - acc_log[k-1], out_log[k] - out_log[k-1]);
            end
         end
      end
      check_stats(1);
   endtask

   task automatic test_reset_mid_frame();
      send_beat(0, 1, 8, 8'h0F, A_MAX);
      send_beat(0, 2, 8, 8'h0F, A_MAX);
      s_vld[0] = 1'b1;
      s_dat[0] = {$urandom, $urandom};
      s_keep[0] = 8'hFF;
      checks++;
      if (m_vld[0] !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset_valid: got %b, required 1", m_vld[0]);
      end
      #2;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (m_vld[0] !== 1'b0 || s_rdy[0] !== 1'b0) begin
         fails++;
         $display("FAIL midreset_handshake: got vld=%b rdy=%b, required 0 0", m_vld[0], s_rdy[0]);
      end
      checks++;
      if ({m_dat[0], m_keep[0], m_last[0], m_user[0]} !== 74'd0) begin
         fails++;
         $display("FAIL midreset_data: got d=%h k=%h, required 0", m_dat[0], m_keep[0]);
      end
      checks++;
      if ({frame_cnt[0], byte_cnt[0], trunc_cnt[0]} !== 96'd0) begin
         fails++;
         $display("FAIL midreset_stats: got %0d/%0d/%0d, required 0", frame_cnt[0], byte_cnt[0], trunc_cnt[0]);
      end
      s_vld[0] = 1'b0;
      clear_model();
      release_reset();
      send_frame(0, 8, 8'h0F, A_MAX);
      drain();
      check_stats(0);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_vld[i] = 1'b0; s_dat[i] = 64'd0; s_keep[i] = 8'd0; s_last[i] = 1'b0; s_user[i] = 1'b0;
         m_rdy[i] = 1'b1; tog[i] = 1'b0; lat_chk[i] = 1'b0; acc[i] = 1'b0;
      end
      occ_chk = 1'b0;
      saw_full = 1'b0;
      clear_model();
      test_reset();
      test_frame_60b();
      test_backpressure();
      test_truncate();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/eth_tx_pacer.md
ETH_TX_PACER -- requirements
Module: eth_tx_pacer

Interface
REQ-001 SHALL have parameter ifg_len, default 28'd16, idle cycles forced between frames at the input side.
REQ-002 SHALL have parameter max_beats, default 16'd128, maximum beats per frame before truncation.
REQ-003 SHALL have ports: clk156  in  1  the single clock; sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports s_axis_tx_tvalid in 1, s_axis_tx_tready out 1, s_axis_tx_tdata in 64, s_axis_tx_tkeep in 8, s_axis_tx_tlast in 1, s_axis_tx_tuser in 1: frames from the packet generator.
REQ-005 SHALL have ports m_axis_tx_tvalid out 1, m_axis_tx_tready in 1, m_axis_tx_tdata out 64, m_axis_tx_tkeep out 8, m_axis_tx_tlast out 1, m_axis_tx_tuser out 1: frames toward the MAC.
REQ-006 SHALL have ports frame_cnt out 32, byte_cnt out 48, trunc_cnt out 16: statistics (see Configuration).

Function
REQ-007 SHALL transfer a beat on either side only when tvalid and tready are both high on a clk156 edge.
REQ-008 SHALL forward each accepted input beat unchanged (data, keep, last, user) with exactly 1 cycle latency when m_axis_tx_tready is high.
REQ-009 SHALL buffer up to 2 beats so s_axis_tx_tready is a registered signal with no combinational path from m_axis_tx_tready.
REQ-010 SHALL implement states P_IDLE, P_FRAME, P_DROP, P_GAP.
REQ-011 P_IDLE -> P_FRAME on first accepted beat without tlast; a single-beat frame (tlast on first beat) goes P_IDLE -> P_GAP.
REQ-012 P_FRAME -> P_GAP on accepted beat with tlast; beat counter resets to 0.
REQ-013 On accepting beat number max_beats without tlast, SHALL emit that beat with tlast=1 and tuser=1 and go to P_DROP.
REQ-014 In P_DROP SHALL hold s_axis_tx_tready high, discard all beats, and go to P_GAP on the accepted tlast beat.
REQ-015 In P_GAP SHALL hold s_axis_tx_tready low for exactly ifg_len cycles starting the cycle after the tlast acceptance, then go to P_IDLE.
REQ-016 ifg_len=0 SHALL skip P_GAP (back-to-back frames, tready continuous).
REQ-017 Gap counter SHALL be 28 bits and saturate, never wrap.
REQ-018 SHALL pass tkeep unmodified; tkeep is low-byte-contiguous and byte count of a beat is the popcount of tkeep.

Reset
REQ-019 sys_rst_n low SHALL immediately clear: both tvalid/tready outputs 0, m_axis_tx_tdata/tkeep/tlast/tuser 0, buffer empty, state P_IDLE, all counters 0.
REQ-020 Reset asserted mid-frame SHALL drop the partial frame; after release the first accepted beat starts a new frame.
REQ-021 s_axis_tx_tready SHALL rise no earlier than the second clk156 edge after sys_rst_n deasserts.

Configuration
REQ-022 With macro ETH_TX_PACER_STATS_EN defined: frame_cnt +1 per output tlast handshake, byte_cnt += popcount(tkeep) per output handshake, trunc_cnt +1 per truncation; all wrap modulo their width.
REQ-023 Without ETH_TX_PACER_STATS_EN: frame_cnt, byte_cnt, trunc_cnt SHALL be tied to 0 and no counter logic instantiated.

Structure
REQ-024 State enum pacer_state_t and function keep_bytes() (8-bit tkeep -> 4-bit count) SHALL live in ethernet_pkg.
REQ-025 The 2-entry output buffer SHALL be sub-module axis_skid_buf (64-bit data, 8-bit keep, last, user).

Verification
REQ-026 60B frame, 8 beats, last tkeep 8'h0F, ifg_len=4, m_tready=1 -> identical 8 beats out 1 cycle late, byte_cnt=60, frame_cnt=1, s_tready low exactly 4 cycles after tlast.
REQ-027 Same frame, m_tready toggled 1010... -> no beat lost/duplicated, output order preserved, s_tready deasserts when 2 beats held.
REQ-028 max_beats=4, 6-beat frame -> 4 beats out, 4th with tlast=1 tuser=1; beats 5-6 discarded; trunc_cnt=1; next frame unaffected.
REQ-029 ifg_len=0, three 1-beat frames back-to-back -> 3 output beats on 3 consecutive cycles, frame_cnt=3.
REQ-030 sys_rst_n pulsed low at beat 3 of 8 -> m_tvalid 0 same cycle, counters 0; next frame after release passes intact.
REQ-031 Build without ETH_TX_PACER_STATS_EN, run REQ-026 -> data path identical, all stats outputs 0.
